// File: rtl/uart_axil_master_pkg.sv
// Shared constants, state encoding and helpers for the UART-to-AXI4-Lite bridge.
package uart_axil_pkg;

   // Command opcodes seen on the rx byte stream
   localparam logic [7:0] CMD_WRITE   = 8'h57;   // 'W'
   localparam logic [7:0] CMD_READ    = 8'h52;   // 'R'

   // Upper nibble of every status byte; the low two bits carry the AXI response
   localparam logic [7:0] STATUS_BASE = 8'hA0;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Bus geometry
   localparam int AXI_AW = 32;
   localparam int AXI_DW = 32;

   // Bridge sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,   // waiting for an opcode byte
      ST_ADDR  = 3'd1,   // collecting 4 address bytes
      ST_DATA  = 3'd2,   // collecting 4 write-data bytes
      ST_WRITE = 3'd3,   // AW and W channels in flight
      ST_BRESP = 3'd4,   // waiting for the write response
      ST_READ  = 3'd5,   // AR channel in flight
      ST_RDATA = 3'd6,   // waiting for read data
      ST_SEND  = 3'd7    // streaming the response bytes out
   } state_t;

   // Status byte returned to the host for a given AXI response
   function automatic logic [7:0] status_byte(input logic [1:0] resp);
      return STATUS_BASE | {6'b00_0000, resp};
   endfunction

endpackage

// File: rtl/uart_axil_master_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a register responder (slave).
interface uart_axil_master_if;
   import uart_axil_pkg::*;

   // Write address channel
   logic              awvalid;
   logic              awready;
   logic [AXI_AW-1:0] awaddr;
   logic [2:0]        awprot;
   // Write data channel
   logic              wvalid;
   logic              wready;
   logic [AXI_DW-1:0] wdata;
   logic [3:0]        wstrb;
   // Write response channel
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   // Read address channel
   logic              arvalid;
   logic              arready;
   logic [AXI_AW-1:0] araddr;
   logic [2:0]        arprot;
   // Read data channel
   logic              rvalid;
   logic              rready;
   logic [AXI_DW-1:0] rdata;
   logic [1:0]        rresp;

   modport master (
      output awvalid, awaddr, awprot,
      input  awready,
      output wvalid, wdata, wstrb,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr, arprot,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awprot,
      output awready,
      input  wvalid, wdata, wstrb,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr, arprot,
      output arready,
      output rvalid, rdata, rresp,
      input  rready
   );

endinterface

// File: rtl/uart_axil_master.sv
// UART-to-AXI4-Lite bridge: parses 'W'/'R' command frames from the rx byte
// stream, issues one AXI4-Lite access per frame and streams the status byte
// (plus read data for reads) back out on the tx byte stream.
module uart_axil_master
   import uart_axil_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000   // idle cycles tolerated inside a frame, >= 2
) (
   input  logic       clk,
   input  logic       rst,
   // Command byte stream (from rx FIFO)
   input  logic       i_rx_tvalid,
   output logic       o_rx_tready,
   input  logic [7:0] i_rx_tdata,
   // Response byte stream (to tx FIFO)
   output logic       o_tx_tvalid,
   input  logic       i_tx_tready,
   output logic [7:0] o_tx_tdata,
   // AXI4-Lite initiator port
   uart_axil_master_if.master axi
);

   // Last timer value before the frame is abandoned
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t            r_state;
   logic              r_is_write;   // frame opcode was 'W'
   logic [1:0]        r_byte_cnt;   // byte position within the 4-byte field
   logic [31:0]       r_timer;      // idle cycles since last accepted byte
   logic [AXI_AW-1:0] r_addr;       // assembled address, drives awaddr/araddr
   logic [AXI_DW-1:0] r_wdata;      // assembled write data
   logic [AXI_DW-1:0] r_rdata;      // read data, shifted out MSB-first
   logic [2:0]        r_tx_left;    // response bytes still to send after the current one

   // Registered handshake outputs
   logic              r_rx_tready;
   logic              r_tx_tvalid;
   logic [7:0]        r_tx_tdata;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_bready;
   logic              r_arvalid;
   logic              r_rready;

   // ------------------------------------------------------------------
   // Handshake decodes
   // ------------------------------------------------------------------
   logic w_rx_fire;
   logic w_tx_fire;
   logic w_aw_fire;
   logic w_w_fire;
   logic w_b_fire;
   logic w_ar_fire;
   logic w_r_fire;
   logic w_aw_done;
   logic w_w_done;
   logic w_field_end;
   logic w_timeout;
   logic w_is_cmd;

   assign w_rx_fire   = i_rx_tvalid & r_rx_tready;
   assign w_tx_fire   = r_tx_tvalid & i_tx_tready;
   assign w_aw_fire   = r_awvalid & axi.awready;
   assign w_w_fire    = r_wvalid & axi.wready;
   assign w_b_fire    = r_bready & axi.bvalid;
   assign w_ar_fire   = r_arvalid & axi.arready;
   assign w_r_fire    = r_rready & axi.rvalid;
   // A write channel is finished once its valid has dropped or is handshaking now
   assign w_aw_done   = ~r_awvalid | w_aw_fire;
   assign w_w_done    = ~r_wvalid | w_w_fire;
   assign w_field_end = (r_byte_cnt == 2'd3);
   assign w_timeout   = (r_timer == TMO_LAST);
   assign w_is_cmd    = (i_rx_tdata == CMD_WRITE) || (i_rx_tdata == CMD_READ);

   // ------------------------------------------------------------------
   // Bridge sequencer: frame parsing, AXI issue, response streaming
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_is_write  <= 1'b0;
         r_byte_cnt  <= 2'd0;
         r_timer     <= 32'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_tx_left   <= 3'd0;
         r_rx_tready <= 1'b0;
         r_tx_tvalid <= 1'b0;
         r_tx_tdata  <= 8'h00;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
      end else begin
         case (r_state)
            // Hunt for an opcode; anything else is silently dropped
            ST_IDLE: begin
               r_rx_tready <= 1'b1;
               if (w_rx_fire && w_is_cmd) begin
                  r_is_write <= (i_rx_tdata == CMD_WRITE);
                  r_byte_cnt <= 2'd0;
                  r_timer    <= 32'd0;
                  r_state    <= ST_ADDR;
               end
            end

            // Shift in the address MSB-first; reads launch straight after it
            ST_ADDR: begin
               if (w_rx_fire) begin
                  r_addr     <= {r_addr[AXI_AW-9:0], i_rx_tdata};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_timer    <= 32'd0;
                  if (w_field_end) begin
                     if (r_is_write) begin
                        r_state <= ST_DATA;
                     end else begin
                        r_rx_tready <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_state     <= ST_READ;
                     end
                  end
               end else if (w_timeout) begin
                  r_timer <= 32'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end

            // Shift in the write data MSB-first, then raise AW and W together
            ST_DATA: begin
               if (w_rx_fire) begin
                  r_wdata    <= {r_wdata[AXI_DW-9:0], i_rx_tdata};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_timer    <= 32'd0;
                  if (w_field_end) begin
                     r_rx_tready <= 1'b0;
                     r_awvalid   <= 1'b1;
                     r_wvalid    <= 1'b1;
                     r_state     <= ST_WRITE;
                  end
               end else if (w_timeout) begin
                  r_timer <= 32'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end

            // AW and W complete independently, in either order
            ST_WRITE: begin
               if (w_aw_fire) begin
                  r_awvalid <= 1'b0;
               end
               if (w_w_fire) begin
                  r_wvalid <= 1'b0;
               end
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_BRESP;
               end
            end

            // Capture the write response straight into the status byte
            ST_BRESP: begin
               if (w_b_fire) begin
                  r_bready    <= 1'b0;
                  r_tx_tvalid <= 1'b1;
                  r_tx_tdata  <= status_byte(axi.bresp);
                  r_tx_left   <= 3'd0;
                  r_state     <= ST_SEND;
               end
            end

            // Hold the read address until accepted
            ST_READ: begin
               if (w_ar_fire) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RDATA;
               end
            end

            // Capture read data and response; status goes out first
            ST_RDATA: begin
               if (w_r_fire) begin
                  r_rready    <= 1'b0;
                  r_rdata     <= axi.rdata;
                  r_tx_tvalid <= 1'b1;
                  r_tx_tdata  <= status_byte(axi.rresp);
                  r_tx_left   <= 3'd4;
                  r_state     <= ST_SEND;
               end
            end

            // Stream remaining bytes back-to-back; reopen rx after the last one
            ST_SEND: begin
               if (w_tx_fire) begin
                  if (r_tx_left == 3'd0) begin
                     r_tx_tvalid <= 1'b0;
                     r_rx_tready <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_tx_tdata <= r_rdata[AXI_DW-1:AXI_DW-8];
                     r_rdata    <= {r_rdata[AXI_DW-9:0], 8'h00};
                     r_tx_left  <= r_tx_left - 3'd1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign o_rx_tready = r_rx_tready;
   assign o_tx_tvalid = r_tx_tvalid;
   assign o_tx_tdata  = r_tx_tdata;

   assign axi.awvalid = r_awvalid;
   assign axi.awaddr  = r_addr;
   assign axi.awprot  = 3'b000;
   assign axi.wvalid  = r_wvalid;
   assign axi.wdata   = r_wdata;
   assign axi.wstrb   = 4'hF;
   assign axi.bready  = r_bready;
   assign axi.arvalid = r_arvalid;
   assign axi.araddr  = r_addr;
   assign axi.arprot  = 3'b000;
   assign axi.rready  = r_rready;

endmodule

// File: tb/tb_uart_axil_master.sv
// Self-checking bench for uart_axil_master: AXI4-Lite responder BFM with
// configurable delays, tx sink with backpressure, frame driver on rx.
`timescale 1ns/1ps
module tb_uart_axil_master;
   import uart_axil_pkg::*;

   localparam int TMO = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_rx_tvalid = 1'b0;
   logic [7:0] i_rx_tdata = 8'h00;
   logic       o_rx_tready;
   logic       o_tx_tvalid;
   logic       i_tx_tready;
   logic [7:0] o_tx_tdata;

   uart_axil_master_if axi();

   uart_axil_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_tvalid (i_rx_tvalid),
      .o_rx_tready (o_rx_tready),
      .i_rx_tdata  (i_rx_tdata),
      .o_tx_tvalid (o_tx_tvalid),
      .i_tx_tready (i_tx_tready),
      .o_tx_tdata  (o_tx_tdata),
      .axi         (axi)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Responder configuration
   int         cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0, cfg_stall = 0;
   logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;

   // Observations
   int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   int          n_stab_err = 0, n_rx_err = 0, n_valid_seen = 0;
   logic [31:0] obs_awaddr, obs_wdata, obs_araddr;
   logic [3:0]  obs_wstrb;
   logic [2:0]  obs_awprot, obs_arprot;
   int          b_hs_cyc, r_hs_cyc, tx_rise_cyc, last_tx_cyc, rx_rise_cyc;
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];
   int          base_aw, base_w, base_b, base_ar, base_r, base_stab, base_rxerr;
   bit          obs_launch;

   // AXI4-Lite responder: decisions made on negedge take effect at the next posedge
   initial begin
      int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      bit aw_wait, w_wait, ar_wait, aw_pend, w_pend, ar_pend, aw_got, w_got, ar_got, b_pend, r_pend;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      axi.awready = 0; axi.wready = 0; axi.arready = 0;
      axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
      p_awaddr = 0; p_wdata = 0; p_araddr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
            continue;
         end
         if (axi.awvalid || axi.wvalid || axi.arvalid) n_valid_seen++;
         if (aw_pend) begin aw_got = 1; aw_pend = 0; end
         if (w_pend)  begin w_got = 1;  w_pend = 0;  end
         if (ar_pend) begin ar_got = 1; ar_pend = 0; end
         // AW
         axi.awready = 0;
         if (axi.awvalid) begin
            if (aw_wait && axi.awaddr !== p_awaddr) n_stab_err++;
            if (aw_cnt >= cfg_aw_d) begin
               axi.awready = 1; obs_awaddr = axi.awaddr; obs_awprot = axi.awprot;
               n_aw++; aw_cnt = 0; aw_wait = 0; aw_pend = 1;
            end else begin aw_cnt++; aw_wait = 1; p_awaddr = axi.awaddr; end
         end else begin
            if (aw_wait) n_stab_err++;
            aw_wait = 0; aw_cnt = 0;
         end
         // W
         axi.wready = 0;
         if (axi.wvalid) begin
            if (w_wait && axi.wdata !== p_wdata) n_stab_err++;
            if (w_cnt >= cfg_w_d) begin
               axi.wready = 1; obs_wdata = axi.wdata; obs_wstrb = axi.wstrb;
               n_w++; w_cnt = 0; w_wait = 0; w_pend = 1;
            end else begin w_cnt++; w_wait = 1; p_wdata = axi.wdata; end
         end else begin
            if (w_wait) n_stab_err++;
            w_wait = 0; w_cnt = 0;
         end
         // B
         if (b_pend) begin axi.bvalid = 0; b_pend = 0; end
         if (aw_got && w_got && !axi.bvalid) begin
            if (b_cnt >= cfg_b_d) begin
               axi.bvalid = 1; axi.bresp = cfg_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
            end else b_cnt++;
         end
         if (axi.bvalid && axi.bready) begin b_pend = 1; n_b++; b_hs_cyc = cyc + 1; end
         // AR
         axi.arready = 0;
         if (axi.arvalid) begin
            if (ar_wait && axi.araddr !== p_araddr) n_stab_err++;
            if (ar_cnt >= cfg_ar_d) begin
               axi.arready = 1; obs_araddr = axi.araddr; obs_arprot = axi.arprot;
               n_ar++; ar_cnt = 0; ar_wait = 0; ar_pend = 1;
            end else begin ar_cnt++; ar_wait = 1; p_araddr = axi.araddr; end
         end else begin
            if (ar_wait) n_stab_err++;
            ar_wait = 0; ar_cnt = 0;
         end
         // R
         if (r_pend) begin axi.rvalid = 0; r_pend = 0; end
         if (ar_got && !axi.rvalid) begin
            if (r_cnt >= cfg_r_d) begin
               axi.rvalid = 1; axi.rdata = cfg_rdata; axi.rresp = cfg_rresp; ar_got = 0; r_cnt = 0;
            end else r_cnt++;
         end
         if (axi.rvalid && axi.rready) begin r_pend = 1; n_r++; r_hs_cyc = cyc + 1; end
      end
   end

   // Response sink with per-byte stall, stability and rx-gating monitors
   initial begin
      int   stall_cnt;
      bit   t_wait, prev_tv, prev_rxr;
      logic [7:0] p_data;
      i_tx_tready = 0; stall_cnt = 0; t_wait = 0; prev_tv = 0; prev_rxr = 0; p_data = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            i_tx_tready = 0; stall_cnt = 0; t_wait = 0; prev_tv = 0; prev_rxr = 0;
            continue;
         end
         if (o_tx_tvalid && !prev_tv) tx_rise_cyc = cyc;
         if (o_rx_tready && !prev_rxr) rx_rise_cyc = cyc;
         if (t_wait && (!o_tx_tvalid || o_tx_tdata !== p_data)) n_stab_err++;
         if (o_rx_tready && (axi.awvalid || axi.wvalid || axi.arvalid || axi.bready ||
                             axi.rready || o_tx_tvalid)) n_rx_err++;
         i_tx_tready = 0;
         t_wait = 0;
         if (o_tx_tvalid) begin
            if (stall_cnt >= cfg_stall) begin
               i_tx_tready = 1; tx_q.push_back(o_tx_tdata); last_tx_cyc = cyc + 1; stall_cnt = 0;
            end else begin
               stall_cnt++; t_wait = 1; p_data = o_tx_tdata;
            end
         end
         prev_tv = o_tx_tvalid;
         prev_rxr = o_rx_tready;
      end
   end

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   // Expected response: status byte, then read data MSB-first for reads
   function automatic void build_expect(input bit is_wr, input logic [1:0] resp, input logic [31:0] rd);
      exp_q.delete();
      exp_q.push_back(8'hA0 + 8'(resp));
      if (!is_wr)
         for (int i = 0; i < 4; i++) exp_q.push_back(8'((rd >> (24 - 8 * i)) & 32'hFF));
   endfunction

   // Present one rx byte (caller is at a negedge); returns at the negedge after acceptance
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_rx_tvalid = 1; i_rx_tdata = b;
      while (!o_rx_tready && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (!o_rx_tready) begin
         failures++;
         $display("FAIL rx_accept: byte %02h not accepted within 500 cycles, required o_rx_tready=1", b);
      end
      @(negedge clk);
      i_rx_tvalid = 0;
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (tx_q.size() < n && k < 5000) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
   endtask

   // Drive one command frame and collect the response
   task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data, input int gap);
      logic [7:0] fr[$];
      b_hs_cyc = -1; r_hs_cyc = -2; tx_rise_cyc = -3; last_tx_cyc = -4; rx_rise_cyc = -5;
      base_aw = n_aw; base_w = n_w; base_b = n_b; base_ar = n_ar; base_r = n_r;
      base_stab = n_stab_err; base_rxerr = n_rx_err;
      tx_q.delete();
      fr.push_back(is_wr ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) fr.push_back(8'(addr >> (24 - 8 * i)));
      if (is_wr) for (int i = 0; i < 4; i++) fr.push_back(8'(data >> (24 - 8 * i)));
      foreach (fr[i]) begin
         if (i != 0) repeat (gap) @(negedge clk);
         send_byte(fr[i]);
      end
      obs_launch = is_wr ? (axi.awvalid && axi.wvalid && !axi.arvalid)
                         : (axi.arvalid && !axi.awvalid && !axi.wvalid);
      wait_tx(is_wr ? 1 : 5);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({o_rx_tready, o_tx_tvalid, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 7'b0) begin
         failures++;
         $display("FAIL reset_valids: got %b required 0000000",
                  {o_rx_tready, o_tx_tvalid, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
      end
      checks++;
      if ({axi.awaddr, axi.wdata, axi.araddr, o_tx_tdata} !== 104'b0) begin
         failures++;
         $display("FAIL reset_data: awaddr=%h wdata=%h araddr=%h txdata=%h required all 0",
                  axi.awaddr, axi.wdata, axi.araddr, o_tx_tdata);
      end
      rst = 0;
      checks++;
      if (o_rx_tready !== 1'b0) begin
         failures++; $display("FAIL rx_ready_before_edge: got %b required 0", o_rx_tready);
      end
      @(negedge clk);
      checks++;
      if (o_rx_tready !== 1'b1) begin
         failures++; $display("FAIL rx_ready_after_edge: got %b required 1", o_rx_tready);
      end
      $display("test_reset done");
   endtask

   task automatic test_write();
      cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_bresp = 2'b00; cfg_stall = 0;
      run_txn(1, 32'h0000_0004, 32'hDEAD_BEEF, 0);
      build_expect(1, 2'b00, 32'h0);
      checks++;
      if (!obs_launch) begin failures++; $display("FAIL write_launch: aw/w valid not high cycle after last byte, required 1"); end
      checks++;
      if (obs_awaddr !== 32'h4 || obs_wdata !== 32'hDEADBEEF || obs_wstrb !== 4'hF || obs_awprot !== 3'b000) begin
         failures++;
         $display("FAIL write_bus: addr=%h data=%h strb=%h prot=%h required 00000004 deadbeef f 0",
                  obs_awaddr, obs_wdata, obs_wstrb, obs_awprot);
      end
      checks++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'hA0) begin
         failures++; $display("FAIL write_status: got %0d bytes first=%h required 1 byte a0", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
      end
      checks++;
      if (tx_rise_cyc != b_hs_cyc) begin
         failures++; $display("FAIL write_tx_latency: tx valid cycle %0d required %0d", tx_rise_cyc, b_hs_cyc + 0);
      end
      checks++;
      if (rx_rise_cyc != last_tx_cyc) begin
         failures++; $display("FAIL write_rx_reopen: rx ready cycle %0d required %0d", rx_rise_cyc, last_tx_cyc);
      end
      $display("test_write addr=00000004 data=deadbeef tx_bytes=%0d", tx_q.size());
   endtask

   task automatic test_read();
      cfg_ar_d = 0; cfg_r_d = 3; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00; cfg_stall = 0;
      run_txn(0, 32'h0000_0008, 32'h0, 0);
      build_expect(0, 2'b00, 32'h1234_5678);
      checks++;
      if (!obs_launch || obs_araddr !== 32'h8 || obs_arprot !== 3'b000) begin
         failures++; $display("FAIL read_bus: launch=%0d araddr=%h prot=%h required 1 00000008 0", obs_launch, obs_araddr, obs_arprot);
      end
      checks++;
      if (tx_q.size() != exp_q.size()) begin
         failures++; $display("FAIL read_len: got %0d bytes required %0d", tx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
         checks++;
         if (tx_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL read_byte%0d: got %h required %h", i, tx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (tx_rise_cyc != r_hs_cyc || n_aw != base_aw) begin
         failures++; $display("FAIL read_latency: tx valid cycle %0d required %0d, aw count delta %0d required 0",
                              tx_rise_cyc, r_hs_cyc, n_aw - base_aw);
      end
      $display("test_read addr=00000008 tx_bytes=%0d", tx_q.size());
   endtask

   task automatic test_split();
      logic [31:0] a, d;
      a = $urandom; d = $urandom;
      cfg_aw_d = 6; cfg_w_d = 1; cfg_b_d = 1; cfg_bresp = RESP_SLVERR; cfg_stall = 0;
      run_txn(1, a, d, 0);
      checks++;
      if (n_aw - base_aw != 1 || n_w - base_w != 1 || n_b - base_b != 1) begin
         failures++; $display("FAIL split_counts: aw=%0d w=%0d b=%0d required 1 1 1", n_aw - base_aw, n_w - base_w, n_b - base_b);
      end
      checks++;
      if (obs_awaddr !== a || obs_wdata !== d) begin
         failures++; $display("FAIL split_bus: addr=%h data=%h required %h %h", obs_awaddr, obs_wdata, a, d);
      end
      checks++;
      if (n_stab_err != base_stab) begin
         failures++; $display("FAIL split_stable: %0d stability violations required 0", n_stab_err - base_stab);
      end
      checks++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'hA2) begin
         failures++; $display("FAIL split_status: got %0d bytes first=%h required 1 byte a2", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
      end
      $display("test_split addr=%h data=%h tx_bytes=%0d", a, d, tx_q.size());
   endtask

   task automatic test_timeout();
      int base_v;
      logic [31:0] rd;
      tx_q.delete();
      base_v = n_valid_seen;
      send_byte(8'h00);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      repeat (TMO + 10) @(negedge clk);
      checks++;
      if (n_valid_seen != base_v || tx_q.size() != 0) begin
         failures++; $display("FAIL timeout_quiet: axi valid cycles=%0d tx bytes=%0d required 0 0", n_valid_seen - base_v, tx_q.size());
      end
      rd = $urandom;
      cfg_ar_d = 1; cfg_r_d = 0; cfg_rdata = rd; cfg_rresp = 2'b00; cfg_stall = 0;
      run_txn(0, 32'h0000_0010, 32'h0, 0);
      build_expect(0, 2'b00, rd);
      checks++;
      if (tx_q != exp_q || obs_araddr !== 32'h10) begin
         failures++; $display("FAIL timeout_recover: tx=%p araddr=%h required %p 00000010", tx_q, obs_araddr, exp_q);
      end
      // Gaps well inside the timeout must not break a frame
      cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_bresp = 2'b00;
      run_txn(1, 32'hA5A5_0001, 32'h0BAD_F00D, TMO - 10);
      checks++;
      if (obs_wdata !== 32'h0BAD_F00D || tx_q.size() != 1 || tx_q[0] !== 8'hA0) begin
         failures++; $display("FAIL slow_frame: wdata=%h tx bytes=%0d required 0badf00d 1", obs_wdata, tx_q.size());
      end
      $display("test_timeout recovered tx_bytes=%0d", tx_q.size());
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      rd = $urandom;
      cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = rd; cfg_rresp = 2'b00; cfg_stall = 10;
      run_txn(0, 32'h0000_0020, 32'h0, 0);
      build_expect(0, 2'b00, rd);
      checks++;
      if (tx_q != exp_q) begin
         failures++; $display("FAIL bp_bytes: got %p required %p", tx_q, exp_q);
      end
      checks++;
      if (n_stab_err != base_stab || n_rx_err != base_rxerr) begin
         failures++; $display("FAIL bp_hold: stability errs=%0d rx-open errs=%0d required 0 0",
                              n_stab_err - base_stab, n_rx_err - base_rxerr);
      end
      checks++;
      if (rx_rise_cyc != last_tx_cyc) begin
         failures++; $display("FAIL bp_rx_reopen: rx ready cycle %0d required %0d", rx_rise_cyc, last_tx_cyc);
      end
      cfg_stall = 0;
      $display("test_backpressure rdata=%h tx_bytes=%0d", rd, tx_q.size());
   endtask

   task automatic test_reset_mid();
      logic [7:0] fr[$];
      cfg_aw_d = 50; cfg_w_d = 50; cfg_b_d = 0; cfg_stall = 0;
      fr = '{8'h57, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      foreach (fr[i]) send_byte(fr[i]);
      repeat (2) @(negedge clk);
      checks++;
      if (axi.awvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre: awvalid=%b required 1", axi.awvalid); end
      #2 rst = 1;
      #1;
      checks++;
      if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, o_tx_tvalid, o_rx_tready} !== 7'b0) begin
         failures++; $display("FAIL midrst_async: valids=%b required 0000000",
                              {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, o_tx_tvalid, o_rx_tready});
      end
      repeat (2) @(negedge clk);
      rst = 0;
      cfg_aw_d = 0; cfg_w_d = 0; cfg_bresp = 2'b00;
      run_txn(1, 32'hCAFE_0100, 32'h0102_0304, 0);
      checks++;
      if (obs_awaddr !== 32'hCAFE_0100 || obs_wdata !== 32'h0102_0304 || tx_q.size() != 1 || tx_q[0] !== 8'hA0) begin
         failures++; $display("FAIL midrst_after: addr=%h data=%h tx bytes=%0d required cafe0100 01020304 1",
                              obs_awaddr, obs_wdata, tx_q.size());
      end
      $display("test_reset_mid fresh write tx_bytes=%0d", tx_q.size());
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         bit          wr;
         logic [31:0] a, d, rd;
         logic [1:0]  rs;
         wr = 1'($urandom_range(0, 1));
         a = $urandom; d = $urandom; rd = $urandom;
         rs = 2'($urandom_range(0, 3));
         cfg_aw_d = $urandom_range(0, 4); cfg_w_d = $urandom_range(0, 4); cfg_b_d = $urandom_range(0, 4);
         cfg_ar_d = $urandom_range(0, 4); cfg_r_d = $urandom_range(0, 4); cfg_stall = $urandom_range(0, 3);
         cfg_bresp = rs; cfg_rresp = rs; cfg_rdata = rd;
         run_txn(wr, a, d, $urandom_range(0, 3));
         build_expect(wr, rs, rd);
         checks++;
         if (tx_q != exp_q) begin
            failures++; $display("FAIL rand%0d_tx: got %p required %p", t, tx_q, exp_q);
         end
         checks++;
         if (wr ? (obs_awaddr !== a || obs_wdata !== d || n_aw - base_aw != 1 || n_w - base_w != 1 || n_ar != base_ar)
                : (obs_araddr !== a || n_ar - base_ar != 1 || n_r - base_r != 1 || n_aw != base_aw)) begin
            failures++; $display("FAIL rand%0d_bus: wr=%0d aw=%h w=%h ar=%h required addr %h data %h", t, wr, obs_awaddr, obs_wdata, obs_araddr, a, d);
         end
         checks++;
         if (!obs_launch || n_stab_err != base_stab || n_rx_err != base_rxerr || rx_rise_cyc != last_tx_cyc ||
             tx_rise_cyc != (wr ? b_hs_cyc : r_hs_cyc)) begin
            failures++; $display("FAIL rand%0d_timing: launch=%0d stab=%0d rxerr=%0d rx_rise=%0d/%0d tx_rise=%0d required 1 0 0 equal cycles",
                                 t, obs_launch, n_stab_err - base_stab, n_rx_err - base_rxerr, rx_rise_cyc, last_tx_cyc, tx_rise_cyc);
         end
         $display("rand%0d %s addr=%h data=%h resp=%0d tx_bytes=%0d", t, wr ? "W" : "R", a, wr ? d : rd, rs, tx_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_split();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
